multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Multicycle sequencer for the 8-bit MIPS-style datapath. It fetches each instruction over a shared instruction/data memory, decodes the IR opcode, and steps the datapath through execute, memory and write-back states. Each step is one clock, and memory states wait on a ready handshake. It drives the datapath mux selects and write strobes, replacing the single-cycle decoder when the datapath runs multicycle with one ALU and one memory port.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  6  IR[31:26]; stable except when the IR is written.
- `mem_ready`  in  1  memory completes the current read or write this cycle.
- `pc_write`, `pc_write_cond`, `branch_flip`  out  1 each  PC load unconditional / on branch condition / invert the zero test.
- `i_or_d`  out  1  memory address from PC (0) or ALUOut (1).
- `mem_read`, `mem_write`, `ir_write`  out  1 each  memory strobes and IR load.
- `reg_dst`, `mem_to_reg`, `reg_write`  out  1 each  register-file controls.
- `alu_src_a`  out  1  ALU A input: PC (0) or rs (1).
- `alu_src_b`  out  2  ALU B input: rt=00, const 1=01, sign-extended immediate=10, branch offset=11.
- `alu_op`  out  2  00 add, 01 sub, 10 func field, 11 SLT.
- `pc_source`  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- `instr_done`  out  1  one-cycle pulse in the final cycle of every instruction.
- `illegal_op`  out  1  one-cycle pulse in DECODE for an unknown opcode.
- `state`  out  4  current state, for debug.

## Operation
State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, R_WB 7, EXEC_I 8, I_WB 9, BRANCH 10, JUMP 11. Codes 12–15 return to FETCH. Any strobe not listed for a state is 0.

- FETCH: i_or_d=0, mem_read=1, src_a=0, src_b=01, alu_op=00, pc_source=00.
  - If mem_ready: ir_write=1, pc_write=1, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: src_a=0, src_b=11, alu_op=00 (ALUOut holds the branch target). Next state by opcode:
  - 000000 → EXEC_R.
  - 001000, 001001, 001010 → EXEC_I.
  - 100011, 101011 → MEM_ADDR.
  - 000100, 000001, 000011, 000101 → BRANCH.
  - 000010 → JUMP.
  - 111111 → FETCH, with instr_done=1.
  - Any other opcode → FETCH, with illegal_op=1 and instr_done=1.
- EXEC_R: src_a=1, src_b=00, alu_op=10.
- R_WB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1, then FETCH.
- EXEC_I: src_a=1, src_b=10; alu_op=01 for 001001, otherwise 00.
- I_WB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1, then FETCH.
- MEM_ADDR: src_a=1, src_b=10, alu_op=00. Goes to MEM_RD for 100011 and MEM_WR for 101011.
- MEM_RD: i_or_d=1, mem_read=1. Goes to MEM_WB when mem_ready, otherwise holds.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1, then FETCH.
- MEM_WR: i_or_d=1, mem_write=1. When mem_ready: instr_done=1, go to FETCH. Otherwise hold.
- BRANCH: src_a=1, src_b=00, pc_write_cond=1, pc_source=01, instr_done=1, then FETCH.
  - alu_op: 01 for BEQ and BNE, 11 for BLT and BGE.
  - branch_flip=1 for BNE and BLT.
- JUMP: pc_write=1, pc_source=10, instr_done=1, then FETCH.
- Opcode is sampled combinationally in every state. It only changes on ir_write, so decisions after DECODE stay consistent.

## Timing
- Cycle counts with zero memory wait:

  | Instruction | Cycles |
  |---|---|
  | NOP / illegal | 2 |
  | Branch, J | 3 |
  | R, I-type, SW | 4 |
  | LW | 5 |

  Each cycle mem_ready is low in FETCH, MEM_RD or MEM_WR adds one cycle.
- Outputs are combinational from state, opcode and mem_ready. Only the state register is sequential.
- While mem_ready is low:
  - mem_read, mem_write and i_or_d stay asserted and stable.
  - No pc_write, ir_write or reg_write is issued.
- Reset:
  - rst=1 at an edge loads FETCH, regardless of the current state, including mid-memory-wait.
  - While rst=1, every strobe is forced to 0: pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write, instr_done, illegal_op. Selects read 0. state reads 0.
  - In the first cycle after rst deasserts, FETCH asserts mem_read=1.
- A mem_ready pulse in a non-memory state is ignored.

## Configuration
- `BRANCH_EXT_EN`:
  - Defined: BNE (000001), BLT (000011) and BGE (000101) go to BRANCH as specified above.
  - Undefined: those three opcodes decode as illegal (illegal_op pulse, return to FETCH), only BEQ branches, and branch_flip is tied to 0.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - the state enum;
  - the opcode constants (OP_RTYPE, OP_ADDI, OP_SUBI, OP_LWI, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_J, OP_LW, OP_SW, OP_NOP);
  - the ALU_OP, SRC_B and PC_SRC encodings.
- One sub-module, `mc_ctrl_outdec`: a purely combinational decoder from (state, opcode, mem_ready) to the control outputs.
- The top module keeps the state register and next-state logic.

## Test plan
- R-type, mem_ready always 1: states go 0→1→6→7→0. The R_WB cycle shows reg_dst=1, reg_write=1, instr_done=1.
- LW with mem_ready low for 2 cycles in MEM_RD: MEM_RD lasts 3 cycles with mem_read=1 and i_or_d=1. Total 7 cycles; MEM_WB shows mem_to_reg=1.
- BNE, macro on: BRANCH shows alu_op=01, branch_flip=1, pc_write_cond=1, pc_source=01. Macro off: the same opcode gives an illegal_op pulse in DECODE and a return to FETCH.
- FETCH with mem_ready low for 3 cycles: ir_write and pc_write stay 0 until mem_ready=1. Then both are 1 for exactly one cycle.
- rst asserted in MEM_WR while waiting: next state is 0 and mem_write drops to 0. After release, FETCH asserts mem_read=1.
- Opcode 111111, then 110000: each takes 2 cycles. Only the second pulses illegal_op=1.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and constants for the multicycle control sequencer.
// Honours BRANCH_EXT_EN (BNE/BLT/BGE decode); without it only BEQ branches.
package cpu_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_EXEC_R   = 4'd6,
        ST_R_WB     = 4'd7,
        ST_EXEC_I   = 4'd8,
        ST_I_WB     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11
    } state_e;

    // Plain-vector state codes for the state register and decoders
    localparam logic [STATE_W-1:0] S_FETCH    = 4'(ST_FETCH);
    localparam logic [STATE_W-1:0] S_DECODE   = 4'(ST_DECODE);
    localparam logic [STATE_W-1:0] S_MEM_ADDR = 4'(ST_MEM_ADDR);
    localparam logic [STATE_W-1:0] S_MEM_RD   = 4'(ST_MEM_RD);
    localparam logic [STATE_W-1:0] S_MEM_WB   = 4'(ST_MEM_WB);
    localparam logic [STATE_W-1:0] S_MEM_WR   = 4'(ST_MEM_WR);
    localparam logic [STATE_W-1:0] S_EXEC_R   = 4'(ST_EXEC_R);
    localparam logic [STATE_W-1:0] S_R_WB     = 4'(ST_R_WB);
    localparam logic [STATE_W-1:0] S_EXEC_I   = 4'(ST_EXEC_I);
    localparam logic [STATE_W-1:0] S_I_WB     = 4'(ST_I_WB);
    localparam logic [STATE_W-1:0] S_BRANCH   = 4'(ST_BRANCH);
    localparam logic [STATE_W-1:0] S_JUMP     = 4'(ST_JUMP);

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SUBI  = 6'b001001;
    localparam logic [OP_W-1:0] OP_LWI   = 6'b001010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000001;
    localparam logic [OP_W-1:0] OP_BLT   = 6'b000011;
    localparam logic [OP_W-1:0] OP_BGE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_NOP   = 6'b111111;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_FUNC = 2'b10,
        ALU_SLT  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_B_RT   = 2'b00,
        SRC_B_ONE  = 2'b01,
        SRC_B_IMM  = 2'b10,
        SRC_B_BOFF = 2'b11
    } src_b_e;

    typedef enum logic [1:0] {
        PC_SRC_ALU    = 2'b00,
        PC_SRC_ALUOUT = 2'b01,
        PC_SRC_JUMP   = 2'b10
    } pc_src_e;

    // Full set of datapath controls produced for one cycle
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_flip;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_branch_op(input logic [OP_W-1:0] op);
`ifdef BRANCH_EXT_EN
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_BGE);
`else
        return (op == OP_BEQ);
`endif
    endfunction

    function automatic logic is_known_op(input logic [OP_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_SUBI) ||
               (op == OP_LWI) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_J) || (op == OP_NOP) || is_branch_op(op);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multicycle sequencer (master) and the datapath (slave).
interface multicycle_control_fsm_if;

    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_flip;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, branch_flip, i_or_d,
               mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_source,
               instr_done, illegal_op, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, branch_flip, i_or_d,
               mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_source,
               instr_done, illegal_op, state
    );

endinterface

// File: rtl/multicycle_control_fsm_outdec.sv
// Combinational control decoder: (state, opcode, mem_ready) -> datapath controls.
// Honours BRANCH_EXT_EN for the BNE/BLT/BGE ALU op and branch_flip.
module mc_ctrl_outdec
    import cpu_ctrl_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    input  logic [OP_W-1:0]    opcode,
    input  logic               mem_ready,
    output ctrl_t              ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRC_B_ONE;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PC_SRC_ALU;
                // PC+1 and IR load only once the instruction word is on the bus
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRC_B_BOFF;
                ctrl.alu_op     = ALU_ADD;
                ctrl.illegal_op = !is_known_op(opcode);
                ctrl.instr_done = !is_known_op(opcode) || (opcode == OP_NOP);
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.i_or_d     = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_RT;
                ctrl.alu_op    = ALU_FUNC;
            end
            S_R_WB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = (opcode == OP_SUBI) ? ALU_SUB : ALU_ADD;
            end
            S_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRC_B_RT;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_SRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
`ifdef BRANCH_EXT_EN
                // BLT/BGE compare via SLT; BNE/BLT take the inverted zero test
                ctrl.alu_op      = ((opcode == OP_BLT) || (opcode == OP_BGE)) ? ALU_SLT : ALU_SUB;
                ctrl.branch_flip = (opcode == OP_BNE) || (opcode == OP_BLT);
`else
                ctrl.alu_op      = ALU_SUB;
                ctrl.branch_flip = 1'b0;
`endif
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PC_SRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle sequencer top: state register, next-state logic and reset gating.
// Honours BRANCH_EXT_EN (extended branch decode) through cpu_ctrl_pkg.
module multicycle_control_fsm
    import cpu_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    multicycle_control_fsm_if.master bus
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    ctrl_t              ctrl_dec;
    ctrl_t              ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; unused codes fall back to FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (bus.opcode == OP_RTYPE) begin
                    state_d = S_EXEC_R;
                end else if ((bus.opcode == OP_ADDI) || (bus.opcode == OP_SUBI) ||
                             (bus.opcode == OP_LWI)) begin
                    state_d = S_EXEC_I;
                end else if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW)) begin
                    state_d = S_MEM_ADDR;
                end else if (is_branch_op(bus.opcode)) begin
                    state_d = S_BRANCH;
                end else if (bus.opcode == OP_J) begin
                    state_d = S_JUMP;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM_ADDR: begin
                if (bus.opcode == OP_LW) begin
                    state_d = S_MEM_RD;
                end else if (bus.opcode == OP_SW) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM_RD: state_d = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR: state_d = bus.mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC_R: state_d = S_R_WB;
            S_EXEC_I: state_d = S_I_WB;
            default:  state_d = S_FETCH;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .state     (state_q),
        .opcode    (bus.opcode),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl_dec)
    );

    // Reset holds every strobe, select and the debug state at zero
    assign ctrl = rst ? '0 : ctrl_dec;

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.branch_flip   = ctrl.branch_flip;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.instr_done    = ctrl.instr_done;
    assign bus.illegal_op    = ctrl.illegal_op;
    assign bus.state         = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: per-instruction phase model with directed and random programs.
module tb_multicycle_control_fsm;
    import cpu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic [5:0]  cur_op;

    typedef enum int {K_NOP, K_ILL, K_R, K_I, K_LW, K_SW, K_BR, K_J} kind_e;

    typedef struct {
        logic [3:0] st;
        logic       rdy;
        logic [5:0] op;
    } step_t;

    // Instruction class from the opcode table
    function automatic kind_e kind_of(input logic [5:0] op);
        case (op)
            6'b000000:                       return K_R;
            6'b001000, 6'b001001, 6'b001010: return K_I;
            6'b100011:                       return K_LW;
            6'b101011:                       return K_SW;
            6'b000100:                       return K_BR;
`ifdef BRANCH_EXT_EN
            6'b000001, 6'b000011, 6'b000101: return K_BR;
`endif
            6'b000010:                       return K_J;
            6'b111111:                       return K_NOP;
            default:                         return K_ILL;
        endcase
    endfunction

    // Expected controls for one cycle in a given step of an instruction
    function automatic ctrl_t expected(input logic [3:0] st, input logic [5:0] op, input logic rdy);
        ctrl_t c;
        kind_e k;
        c = '0;
        k = kind_of(op);
        case (st)
            4'd0: begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
            4'd1: begin
                c.alu_src_b  = 2'b11;
                c.illegal_op = (k == K_ILL);
                c.instr_done = (k == K_ILL) || (k == K_NOP);
            end
            4'd2: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            4'd3: begin c.i_or_d = 1; c.mem_read = 1; end
            4'd4: begin c.mem_to_reg = 1; c.reg_write = 1; c.instr_done = 1; end
            4'd5: begin c.i_or_d = 1; c.mem_write = 1; c.instr_done = rdy; end
            4'd6: begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            4'd7: begin c.reg_dst = 1; c.reg_write = 1; c.instr_done = 1; end
            4'd8: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = (op == 6'b001001) ? 2'b01 : 2'b00; end
            4'd9: begin c.reg_write = 1; c.instr_done = 1; end
            4'd10: begin
                c.alu_src_a     = 1;
                c.pc_write_cond = 1;
                c.pc_source     = 2'b01;
                c.instr_done    = 1;
                c.alu_op        = ((op == 6'b000011) || (op == 6'b000101)) ? 2'b11 : 2'b01;
                c.branch_flip   = (op == 6'b000001) || (op == 6'b000011);
            end
            4'd11: begin c.pc_write = 1; c.pc_source = 2'b10; c.instr_done = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ctrl_t observed();
        ctrl_t c;
        c.pc_write      = bus.pc_write;
        c.pc_write_cond = bus.pc_write_cond;
        c.branch_flip   = bus.branch_flip;
        c.i_or_d        = bus.i_or_d;
        c.mem_read      = bus.mem_read;
        c.mem_write     = bus.mem_write;
        c.ir_write      = bus.ir_write;
        c.reg_dst       = bus.reg_dst;
        c.mem_to_reg    = bus.mem_to_reg;
        c.reg_write     = bus.reg_write;
        c.alu_src_a     = bus.alu_src_a;
        c.alu_src_b     = bus.alu_src_b;
        c.alu_op        = bus.alu_op;
        c.pc_source     = bus.pc_source;
        c.instr_done    = bus.instr_done;
        c.illegal_op    = bus.illegal_op;
        return c;
    endfunction

    // One clock: drive inputs on the falling edge, check just after
    task automatic apply(input logic r, input logic [5:0] op, input logic rdy,
                         input logic [3:0] st, input ctrl_t c);
        ctrl_t obs;
        @(negedge clk);
        rst           = r;
        bus.opcode    = op;
        bus.mem_ready = rdy;
        #1;
        obs = observed();
        n_vec++;
        assert (bus.state === st)
        else begin
            n_bad++;
            $error("FAIL state op=%b rst=%0d: got %0d want %0d", op, r, bus.state, st);
        end
        n_vec++;
        assert (obs === c)
        else begin
            n_bad++;
            $error("FAIL ctrl op=%b st=%0d rdy=%0d: got %h want %h", op, st, rdy, obs, c);
        end
    endtask

    // Build the step list for one instruction and walk it
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        step_t q[$];
        step_t s;
        kind_e k;
        k = kind_of(op);
        for (int i = 0; i < fw; i++) begin
            s = '{4'd0, 1'b0, cur_op}; q.push_back(s);
        end
        s = '{4'd0, 1'b1, cur_op}; q.push_back(s);
        s = '{4'd1, 1'($urandom_range(0, 1)), op}; q.push_back(s);
        case (k)
            K_R:  begin s = '{4'd6, 1'($urandom_range(0, 1)), op}; q.push_back(s);
                        s = '{4'd7, 1'($urandom_range(0, 1)), op}; q.push_back(s); end
            K_I:  begin s = '{4'd8, 1'($urandom_range(0, 1)), op}; q.push_back(s);
                        s = '{4'd9, 1'($urandom_range(0, 1)), op}; q.push_back(s); end
            K_LW: begin
                s = '{4'd2, 1'($urandom_range(0, 1)), op}; q.push_back(s);
                for (int i = 0; i < mw; i++) begin s = '{4'd3, 1'b0, op}; q.push_back(s); end
                s = '{4'd3, 1'b1, op}; q.push_back(s);
                s = '{4'd4, 1'($urandom_range(0, 1)), op}; q.push_back(s);
            end
            K_SW: begin
                s = '{4'd2, 1'($urandom_range(0, 1)), op}; q.push_back(s);
                for (int i = 0; i < mw; i++) begin s = '{4'd5, 1'b0, op}; q.push_back(s); end
                s = '{4'd5, 1'b1, op}; q.push_back(s);
            end
            K_BR: begin s = '{4'd10, 1'($urandom_range(0, 1)), op}; q.push_back(s); end
            K_J:  begin s = '{4'd11, 1'($urandom_range(0, 1)), op}; q.push_back(s); end
            default: ;
        endcase
        foreach (q[i]) apply(1'b0, q[i].op, q[i].rdy, q[i].st, expected(q[i].st, q[i].op, q[i].rdy));
        cur_op = op;
    endtask

    logic [5:0] op_tbl [12];

    initial begin
        op_tbl = '{OP_RTYPE, OP_ADDI, OP_SUBI, OP_LWI, OP_BEQ, OP_BNE,
                   OP_BLT, OP_BGE, OP_J, OP_LW, OP_SW, OP_NOP};
        rst           = 1'b1;
        bus.opcode    = OP_NOP;
        bus.mem_ready = 1'b0;
        cur_op        = OP_NOP;

        apply(1'b1, OP_NOP, 1'b0, 4'd0, '0);
        apply(1'b1, OP_SW,  1'b1, 4'd0, '0);

        // Directed programs
        run_instr(OP_RTYPE, 0, 0);
        run_instr(OP_LW, 0, 2);
        run_instr(OP_BNE, 0, 0);
        run_instr(OP_ADDI, 3, 0);
        run_instr(OP_SW, 1, 2);
        run_instr(OP_NOP, 0, 0);
        run_instr(6'b110000, 0, 0);

        // Reset while MEM_WR waits on memory
        apply(1'b0, cur_op, 1'b1, 4'd0, expected(4'd0, cur_op, 1'b1));
        apply(1'b0, OP_SW, 1'b0, 4'd1, expected(4'd1, OP_SW, 1'b0));
        apply(1'b0, OP_SW, 1'b1, 4'd2, expected(4'd2, OP_SW, 1'b1));
        apply(1'b0, OP_SW, 1'b0, 4'd5, expected(4'd5, OP_SW, 1'b0));
        apply(1'b1, OP_SW, 1'b0, 4'd0, '0);
        apply(1'b0, OP_SW, 1'b0, 4'd0, expected(4'd0, OP_SW, 1'b0));
        cur_op = OP_SW;

        foreach (op_tbl[i]) run_instr(op_tbl[i], 0, 1);

        // Random programs with random memory stalls
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
            else op = op_tbl[$urandom_range(0, 11)];
            run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
